// File: rtl/rx_core_pkg.sv
// rtl/rx_core_pkg.sv - shared receiver-core types and default timing parameters
package rx_core_pkg;

   typedef logic [15:0] phase_inc_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ALIGN,
      APPLY,
      FLUSH
   } rx_state_e;

   localparam int unsigned FLUSH_CYCLES_DEFAULT  = 64;
   localparam int unsigned ALIGN_TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/rx_flush_counter.sv
// rtl/rx_flush_counter.sv - loadable down-counter that flags when a pipeline blanking window ends
module rx_flush_counter #(
   parameter int unsigned      WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Counter parks at zero so done stays asserted until the next load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= RESET_VALUE;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/rx_tune_scheduler.sv
// rtl/rx_tune_scheduler.sv - applies DDS retune requests on the demux path-0 slot and blanks the receiver pipeline afterwards
module rx_tune_scheduler
   import rx_core_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES  = FLUSH_CYCLES_DEFAULT,
   parameter int unsigned ALIGN_TIMEOUT = ALIGN_TIMEOUT_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  phase_inc_t req_complex_inc,
   input  phase_inc_t req_real_inc,
   input  logic       phase_strobe,
   output phase_inc_t complex_phase_inc,
   output phase_inc_t real_phase_inc,
   output logic       rx_data_valid,
   output logic       align_error,
   output logic [15:0] retune_count
);

   localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);
   localparam logic [15:0] WAIT_LIMIT = 16'(ALIGN_TIMEOUT);

   rx_state_e   state_q, state_d;
   phase_inc_t  hold_complex, hold_real;
   logic [15:0] wait_cnt;
   logic        retune_pending;
   logic        accept, timeout, flush_load, flush_dec, flush_done;

   rx_flush_counter #(
      .WIDTH       (16),
      .RESET_VALUE (FLUSH_LOAD)
   ) u_flush (
      .clock      (clock),
      .reset      (reset),
      .load       (flush_load),
      .dec        (flush_dec),
      .load_value (FLUSH_LOAD),
      .done       (flush_done)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FLUSH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      accept     = 1'b0;
      timeout    = 1'b0;
      flush_load = 1'b0;
      flush_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = WAIT_ALIGN;
            end
         end
         WAIT_ALIGN: begin
            if (phase_strobe) begin
               state_d = APPLY;
            end else if (wait_cnt == WAIT_LIMIT) begin
               timeout = 1'b1;
               state_d = APPLY;
            end
         end
         APPLY: begin
            flush_load = 1'b1;
            state_d    = FLUSH;
         end
         FLUSH: begin
            if (flush_done) begin
               state_d = IDLE;
            end else begin
               flush_dec = 1'b1;
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   // retune_pending keeps the reset-time flush from being counted as a retune.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_complex      <= '0;
         hold_real         <= '0;
         wait_cnt          <= '0;
         complex_phase_inc <= '0;
         real_phase_inc    <= '0;
         rx_data_valid     <= 1'b0;
         align_error       <= 1'b0;
         retune_count      <= '0;
         retune_pending    <= 1'b0;
      end else begin
         if (accept) begin
            hold_complex <= req_complex_inc;
            hold_real    <= req_real_inc;
            wait_cnt     <= '0;
         end
         if ((state_q == WAIT_ALIGN) && !phase_strobe && !timeout) begin
            wait_cnt <= wait_cnt + 16'd1;
         end
         if (timeout) begin
            align_error <= 1'b1;
         end
         if (state_q == APPLY) begin
            complex_phase_inc <= hold_complex;
            real_phase_inc    <= hold_real;
            rx_data_valid     <= 1'b0;
            retune_pending    <= 1'b1;
         end
         if ((state_q == FLUSH) && flush_done) begin
            rx_data_valid <= 1'b1;
            if (retune_pending) begin
               retune_count   <= retune_count + 16'd1;
               retune_pending <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_tune_scheduler.sv
// tb/tb_rx_tune_scheduler.sv - directed self-checking bench for rx_tune_scheduler
module tb_rx_tune_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_complex_inc = '0;
   logic [15:0] req_real_inc = '0;
   logic        phase_strobe = 1'b0;
   logic [15:0] complex_phase_inc;
   logic [15:0] real_phase_inc;
   logic        rx_data_valid;
   logic        align_error;
   logic [15:0] retune_count;

   int checks_done = 0;
   int checks_failed = 0;

   rx_tune_scheduler #(.FLUSH_CYCLES(64), .ALIGN_TIMEOUT(8)) dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_complex_inc   (req_complex_inc),
      .req_real_inc      (req_real_inc),
      .phase_strobe      (phase_strobe),
      .complex_phase_inc (complex_phase_inc),
      .real_phase_inc    (real_phase_inc),
      .rx_data_valid     (rx_data_valid),
      .align_error       (align_error),
      .retune_count      (retune_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_done++;
      if (got !== exp) begin
         checks_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Steps until rx_data_valid rises (bounded), strobing every 4 cycles to show FLUSH ignores it.
   task automatic wait_valid(input string tag, input int exp_cycles);
      int n = 0;
      while (!rx_data_valid && n < 200) begin
         phase_strobe = (n % 4 == 0);
         step();
         n++;
      end
      phase_strobe = 1'b0;
      check(tag, n, exp_cycles);
   endtask

   // Accepts a request, waits 'waits' strobe-less cycles, then strobes; leaves the bench just after the update edge.
   task automatic retune(input logic [15:0] c, input logic [15:0] r, input int waits);
      req_complex_inc = c;
      req_real_inc    = r;
      req_valid       = 1'b1;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < waits; i++) step();
      phase_strobe = 1'b1;
      step();
      phase_strobe = 1'b0;
      step();
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_complex", complex_phase_inc, 16'h0);
      check("rst_real", real_phase_inc, 16'h0);
      check("rst_valid", rx_data_valid, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      reset = 1'b0;

      // Initial flush: valid and ready rise 64 cycles after release
      wait_valid("init_flush_len", 64);
      check("init_ready", req_ready, 1'b1);
      check("init_count", retune_count, 16'd0);

      // Strobe two cycles after acceptance; inputs churn after handshake
      req_complex_inc = 16'h1000;
      req_real_inc    = 16'h0800;
      req_valid       = 1'b1;
      step();
      req_valid       = 1'b0;
      req_complex_inc = 16'hDEAD;
      req_real_inc    = 16'hBEEF;
      check("wait_ready_low", req_ready, 1'b0);
      step();
      step();
      phase_strobe = 1'b1;
      step();
      phase_strobe = 1'b0;
      check("pre_apply_complex", complex_phase_inc, 16'h0);
      check("pre_apply_real", real_phase_inc, 16'h0);
      step();
      check("apply_complex", complex_phase_inc, 16'h1000);
      check("apply_real", real_phase_inc, 16'h0800);
      check("apply_valid_low", rx_data_valid, 1'b0);
      wait_valid("flush_len_1", 64);
      check("count_1", retune_count, 16'd1);
      check("no_align_err", align_error, 1'b0);
      check("post_flush_complex", complex_phase_inc, 16'h1000);

      // No strobe: forced apply after 8 waited cycles
      req_complex_inc = 16'h2222;
      req_real_inc    = 16'h3333;
      req_valid       = 1'b1;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("timeout_not_yet", align_error, 1'b0);
      step();
      check("timeout_err", align_error, 1'b1);
      check("timeout_pre_apply", complex_phase_inc, 16'h1000);
      step();
      check("timeout_complex", complex_phase_inc, 16'h2222);
      check("timeout_real", real_phase_inc, 16'h3333);
      wait_valid("flush_len_2", 64);

      // Good retune leaves the sticky error set
      retune(16'h0444, 16'h0555, 0);
      check("good_complex", complex_phase_inc, 16'h0444);
      check("good_real", real_phase_inc, 16'h0555);
      wait_valid("flush_len_3", 64);
      check("err_sticky", align_error, 1'b1);
      check("count_3", retune_count, 16'd3);

      // Second request held high through FLUSH
      req_complex_inc = 16'h1111;
      req_real_inc    = 16'h2222;
      req_valid       = 1'b1;
      step();
      req_complex_inc = 16'h3333;
      req_real_inc    = 16'h4444;
      phase_strobe = 1'b1;
      step();
      phase_strobe = 1'b0;
      step();
      check("held_first_complex", complex_phase_inc, 16'h1111);
      check("held_first_real", real_phase_inc, 16'h2222);
      wait_valid("flush_len_4", 64);
      check("held_ready", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
      check("held_accepted", req_ready, 1'b0);
      phase_strobe = 1'b1;
      step();
      phase_strobe = 1'b0;
      step();
      check("held_second_complex", complex_phase_inc, 16'h3333);
      check("held_second_real", real_phase_inc, 16'h4444);
      wait_valid("flush_len_5", 64);
      check("count_5", retune_count, 16'd5);

      // Reset pulsed during WAIT_ALIGN discards the captured request
      req_complex_inc = 16'hAAAA;
      req_real_inc    = 16'hBBBB;
      req_valid       = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      #2;
      reset = 1'b1;
      #1;
      check("midrst_complex", complex_phase_inc, 16'h0);
      check("midrst_real", real_phase_inc, 16'h0);
      check("midrst_err", align_error, 1'b0);
      check("midrst_ready", req_ready, 1'b0);
      check("midrst_count", retune_count, 16'd0);
      step();
      reset = 1'b0;
      wait_valid("midrst_flush_len", 64);
      check("midrst_never_complex", complex_phase_inc, 16'h0);
      check("midrst_never_real", real_phase_inc, 16'h0);

      // Count wraps from 0xFFFF to 0
      force dut.retune_count = 16'hFFFF;
      step();
      release dut.retune_count;
      retune(16'h0001, 16'h0002, 1);
      wait_valid("flush_len_wrap", 64);
      check("count_wrap", retune_count, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
      $finish;
   end

endmodule

// File: doc/rx_tune_scheduler.md
RX_TUNE_SCHEDULER -- requirements
Module: rx_tune_scheduler

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 64, meaning clock cycles of receiver pipeline latency (DDS, complex multiplier, 4-path FIR, serializer) to blank after a retune; legal range 2..65535.
REQ-002 SHALL have parameter ALIGN_TIMEOUT, default 8, meaning maximum cycles to wait for phase_strobe before a forced apply.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clock and reset.
REQ-004 clock  input  1  sole clock, the receiver sample clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  retune request present.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both high on a clock edge.
REQ-008 req_complex_inc  input  16  requested complex-mixer phase increment.
REQ-009 req_real_inc  input  16  requested real-mixer phase increment.
REQ-010 phase_strobe  input  1  one-cycle pulse every 4 clocks marking the path-0 slot of the 1-to-4 demux.
REQ-011 complex_phase_inc  output  16  registered increment driven to the complex DDS.
REQ-012 real_phase_inc  output  16  registered increment driven to the real DDS.
REQ-013 rx_data_valid  output  1  receiver outputs reflect the current increments.
REQ-014 align_error  output  1  sticky flag: a forced apply occurred without phase_strobe.
REQ-015 retune_count  output  16  number of completed retunes, wrapping.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_ALIGN, APPLY and FLUSH.
REQ-017 req_ready SHALL be high only in IDLE.
REQ-018 In IDLE, an accepted request SHALL capture both increments into holding registers and move the FSM to WAIT_ALIGN.
REQ-019 In WAIT_ALIGN, phase_strobe high SHALL move the FSM to APPLY on the next edge.
REQ-020 In WAIT_ALIGN, if ALIGN_TIMEOUT cycles elapse without phase_strobe, the FSM SHALL move to APPLY and set align_error.
REQ-021 APPLY SHALL last exactly one cycle: both outputs update together on its edge (never one without the other), rx_data_valid deasserts, and the flush counter loads FLUSH_CYCLES-1.
REQ-022 FLUSH SHALL decrement the counter each cycle; at 0 it SHALL return to IDLE, assert rx_data_valid and increment retune_count (wrapping from 0xFFFF to 0x0000).
REQ-023 Changing inputs on req_complex_inc/req_real_inc outside an accepted handshake SHALL have no effect on the outputs.
REQ-024 A request held during WAIT_ALIGN, APPLY or FLUSH SHALL stall, not be dropped; it is accepted in the first IDLE cycle.
REQ-025 phase_strobe during IDLE or FLUSH SHALL be ignored.
REQ-026 Latency SHALL be: accept edge to output update = 1 + cycles waited for the strobe + 1; output update to rx_data_valid = FLUSH_CYCLES.
REQ-027 align_error SHALL clear only on reset.

Reset
REQ-028 Reset SHALL force complex_phase_inc=0, real_phase_inc=0, rx_data_valid=0, align_error=0 and retune_count=0, set the flush counter to FLUSH_CYCLES-1, and place the FSM in FLUSH (initial pipeline flush, req_ready=0).
REQ-029 Reset asserted mid-operation SHALL discard any captured request; no partial increment update SHALL be visible.

Structure
REQ-030 The state enum, the 16-bit phase-increment typedef and the FLUSH_CYCLES/ALIGN_TIMEOUT defaults SHALL live in the shared package rx_core_pkg.
REQ-031 The flush down-counter with load and done outputs SHALL be a sub-module named rx_flush_counter, reusable for other pipeline blanking.

Verification
REQ-032 Release reset, no requests -> rx_data_valid rises exactly 64 cycles after reset release, req_ready rises the same cycle, retune_count=0.
REQ-033 Request 0x1000/0x0800 with phase_strobe 2 cycles after acceptance -> both outputs change on the same edge, 4 cycles after acceptance; rx_data_valid low for 64 cycles; retune_count=1.
REQ-034 No phase_strobe after a request -> apply after 8 wait cycles, align_error=1 and stays 1 across the next good retune.
REQ-035 Second request held high through FLUSH -> accepted in the first IDLE cycle; values apply in order; retune_count=2.
REQ-036 Reset pulsed during WAIT_ALIGN -> outputs 0, align_error 0, FSM in FLUSH; the captured increments never appear.
REQ-037 Preload retune_count at 0xFFFF (force) and complete a retune -> count reads 0x0000.
